// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// IF_PERF_CNT_EN (optional) adds fetch/stall performance counters to if_stage.
package if_pkg;

  localparam int PC_W = 32;

  localparam logic [PC_W-1:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0]     NOP_INSTR_DEF = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } if_state_t;

  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
    return pc & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/if_stage_fetch_skid_buf.sv
// One-entry buffer holding a fetched instruction and its PC while decode is stalled.
module fetch_skid_buf
  import if_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic            i_drain,
  input  logic            i_clear,
  input  logic [31:0]     i_data,
  input  logic [PC_W-1:0] i_pc,
  output logic            o_valid,
  output logic [31:0]     o_data,
  output logic [PC_W-1:0] o_pc
);

  logic            r_valid;
  logic [31:0]     r_data;
  logic [PC_W-1:0] r_pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_pc    <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_pc    <= i_pc;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_pc    = r_pc;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, memory req/gnt/rvalid handshake and the IF/ID register.
// Optional IF_PERF_CNT_EN adds perf_fetch_cnt / perf_stall_cnt outputs.
//
// state | meaning
// IDLE  | out of reset, no request yet
// REQ   | im_req high at pc, waiting for grant
// WAIT  | request granted, waiting for rvalid (kill drops it)
// HOLD  | response parked in skid buffer until stall falls
module if_stage
  import if_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0]     NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            im_req,
  output logic [PC_W-1:0] im_addr,
  input  logic            im_gnt,
  input  logic            im_rvalid,
  input  logic [31:0]     im_rdata,
  output logic [PC_W-1:0] IF_pc_out,
  output logic [31:0]     IF_instr_out,
  output logic            IF_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_stall_cnt
`endif
);

  if_state_t       r_state, w_state_nxt;
  logic [PC_W-1:0] r_pc, w_pc_nxt;
  logic            r_kill, w_kill_nxt;
  logic            w_if_load, w_buf_load, w_buf_drain, w_buf_clear;
  logic            w_buf_valid;
  logic [31:0]     w_buf_data, w_if_instr;
  logic [PC_W-1:0] w_buf_pc, w_if_pc, w_redir_pc;
  logic            w_rsp_ok;

  assign w_redir_pc = align_pc(redirect_pc);
  assign w_rsp_ok   = (r_state == S_WAIT) && im_rvalid && !r_kill && !redirect;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_kill  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_kill  <= w_kill_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: w_state_nxt = S_REQ;
      S_REQ:  if (im_gnt) w_state_nxt = S_WAIT;
      S_WAIT: if (im_rvalid) w_state_nxt = (w_rsp_ok && stall) ? S_HOLD : S_REQ;
      S_HOLD: if (redirect || !stall) w_state_nxt = S_REQ;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_pc_nxt    = redirect ? w_redir_pc : r_pc;
    w_kill_nxt  = r_kill;
    w_if_load   = 1'b0;
    w_buf_load  = 1'b0;
    w_buf_drain = 1'b0;
    w_buf_clear = 1'b0;
    case (r_state)
      S_REQ: if (im_gnt && redirect) w_kill_nxt = 1'b1;
      S_WAIT: begin
        if (im_rvalid) begin
          w_kill_nxt = 1'b0;
          if (w_rsp_ok && stall) begin
            w_buf_load = 1'b1;
          end else if (w_rsp_ok) begin
            w_if_load = 1'b1;
            w_pc_nxt  = r_pc + 32'd4;
          end
        end else if (redirect) begin
          w_kill_nxt = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          w_buf_clear = 1'b1;
        end else if (!stall && w_buf_valid) begin
          w_if_load   = 1'b1;
          w_buf_drain = 1'b1;
          w_pc_nxt    = r_pc + 32'd4;
        end
      end
      default: ;
    endcase
  end

  assign im_req  = (r_state == S_REQ);
  assign im_addr = r_pc;

  fetch_skid_buf u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_buf_load),
    .i_drain (w_buf_drain),
    .i_clear (w_buf_clear),
    .i_data  (im_rdata),
    .i_pc    (r_pc),
    .o_valid (w_buf_valid),
    .o_data  (w_buf_data),
    .o_pc    (w_buf_pc)
  );

  assign w_if_instr = (r_state == S_HOLD) ? w_buf_data : im_rdata;
  assign w_if_pc    = (r_state == S_HOLD) ? w_buf_pc   : r_pc;

  // Without stall or a new load, decode has consumed IF/ID, so a bubble is inserted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      IF_pc_out    <= '0;
      IF_instr_out <= NOP_INSTR;
      IF_valid     <= 1'b0;
    end else if (redirect) begin
      IF_instr_out <= NOP_INSTR;
      IF_valid     <= 1'b0;
    end else if (w_if_load) begin
      IF_pc_out    <= w_if_pc;
      IF_instr_out <= w_if_instr;
      IF_valid     <= 1'b1;
    end else if (!stall) begin
      IF_instr_out <= NOP_INSTR;
      IF_valid     <= 1'b0;
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (w_if_load)         perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (stall && IF_valid) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage; perf counters checked when IF_PERF_CNT_EN is defined.
module tb_if_stage;

  logic        clk, rst, stall, redirect;
  logic [31:0] redirect_pc;
  logic        im_req, im_gnt, im_rvalid;
  logic [31:0] im_addr, im_rdata;
  logic [31:0] IF_pc_out, IF_instr_out;
  logic        IF_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  if_stage dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .im_req       (im_req),
    .im_addr      (im_addr),
    .im_gnt       (im_gnt),
    .im_rvalid    (im_rvalid),
    .im_rdata     (im_rdata),
    .IF_pc_out    (IF_pc_out),
    .IF_instr_out (IF_instr_out),
    .IF_valid     (IF_valid)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Grant in the request cycle, response the next cycle: IF/ID loads two edges later.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] data);
    check("fetch_req", {31'd0, im_req}, 32'd1);
    check("fetch_addr", im_addr, addr);
    im_gnt = 1'b1;
    tick();
    im_gnt = 1'b0;
    check("fetch_wait_noreq", {31'd0, im_req}, 32'd0);
    im_rvalid = 1'b1;
    im_rdata  = data;
    tick();
    im_rvalid = 1'b0;
    check("fetch_if_pc", IF_pc_out, addr);
    check("fetch_if_instr", IF_instr_out, data);
    check("fetch_if_valid", {31'd0, IF_valid}, 32'd1);
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    im_gnt = 1'b0; im_rvalid = 1'b0; im_rdata = '0;
    #12;
    check("rst_req", {31'd0, im_req}, 32'd0);
    check("rst_valid", {31'd0, IF_valid}, 32'd0);
    check("rst_instr", IF_instr_out, NOP);
    check("rst_pc", IF_pc_out, 32'h0);
    rst = 1'b1;
    tick();

    fetch(32'h0, 32'hA000_0001);
    fetch(32'h4, 32'hA000_0002);

    // Stall spanning REQ, WAIT and HOLD for the 0x8 fetch
    stall = 1'b1;
    im_gnt = 1'b1;
    tick();
    im_gnt = 1'b0;
    check("stall_hold_pc0", IF_pc_out, 32'h4);
    check("stall_hold_valid0", {31'd0, IF_valid}, 32'd1);
    im_rvalid = 1'b1; im_rdata = 32'hA000_0003;
    tick();
    im_rvalid = 1'b0;
    check("stall_hold_pc1", IF_pc_out, 32'h4);
    check("stall_hold_instr1", IF_instr_out, 32'hA000_0002);
    check("stall_hold_noreq1", {31'd0, im_req}, 32'd0);
    tick();
    check("stall_hold_pc2", IF_pc_out, 32'h4);
    check("stall_hold_noreq2", {31'd0, im_req}, 32'd0);
    stall = 1'b0;
    tick();
    check("unstall_pc", IF_pc_out, 32'h8);
    check("unstall_instr", IF_instr_out, 32'hA000_0003);
    check("unstall_valid", {31'd0, IF_valid}, 32'd1);
    check("unstall_next_addr", im_addr, 32'hC);
    check("unstall_next_req", {31'd0, im_req}, 32'd1);

    // Redirect while waiting for 0xC
    im_gnt = 1'b1;
    tick();
    im_gnt = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    check("redir_valid", {31'd0, IF_valid}, 32'd0);
    check("redir_instr", IF_instr_out, NOP);
    check("redir_pc_kept", IF_pc_out, 32'h8);
    check("redir_still_wait", {31'd0, im_req}, 32'd0);
    im_rvalid = 1'b1; im_rdata = 32'hDEAD_BEEF;
    tick();
    im_rvalid = 1'b0;
    check("redir_discard_req", {31'd0, im_req}, 32'd1);
    check("redir_discard_addr", im_addr, 32'h100);
    check("redir_discard_valid", {31'd0, IF_valid}, 32'd0);
    check("redir_discard_instr", IF_instr_out, NOP);

    fetch(32'h100, 32'hA000_0004);

    // Redirect, rvalid and stall in the same cycle; unaligned target
    im_gnt = 1'b1;
    tick();
    im_gnt = 1'b0;
    im_rvalid = 1'b1; im_rdata = 32'hBAAD_F00D;
    redirect = 1'b1; redirect_pc = 32'h203; stall = 1'b1;
    tick();
    im_rvalid = 1'b0; redirect = 1'b0; stall = 1'b0;
    check("combo_req", {31'd0, im_req}, 32'd1);
    check("combo_addr_aligned", im_addr, 32'h200);
    check("combo_valid", {31'd0, IF_valid}, 32'd0);
    check("combo_pc_kept", IF_pc_out, 32'h100);

    // Redirect in REQ without grant, then PC wrap
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    check("req_redir_addr", im_addr, 32'hFFFF_FFFC);
    fetch(32'hFFFF_FFFC, 32'hA000_0005);
    check("wrap_addr", im_addr, 32'h0);

`ifdef IF_PERF_CNT_EN
    check("perf_fetch", perf_fetch_cnt, 32'd5);
    check("perf_stall", perf_stall_cnt, 32'd3);
`endif

    // Asynchronous reset while in WAIT, with a late response afterwards
    im_gnt = 1'b1;
    tick();
    im_gnt = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("arst_req", {31'd0, im_req}, 32'd0);
    check("arst_valid", {31'd0, IF_valid}, 32'd0);
    check("arst_instr", IF_instr_out, NOP);
    check("arst_pc", IF_pc_out, 32'h0);
    check("arst_addr", im_addr, 32'h0);
    im_rvalid = 1'b1; im_rdata = 32'hBAD0_BAD0;
    #1 rst = 1'b1;
    tick();
    check("post_rst_req", {31'd0, im_req}, 32'd1);
    check("post_rst_addr", im_addr, 32'h0);
    check("post_rst_valid", {31'd0, IF_valid}, 32'd0);
    tick();
    im_rvalid = 1'b0;
    check("spurious_req", {31'd0, im_req}, 32'd1);
    check("spurious_valid", {31'd0, IF_valid}, 32'd0);
    fetch(32'h0, 32'hA000_0006);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage: owns the PC and runs a request/grant/response handshake with instruction memory.
- Registers the fetched instruction and its PC into the IF/ID pipeline register, which feeds the decode stage.
- Honours stall from the hazard unit and redirect (branch/jump flush) from execute; redirect always wins.

Parameters:
RESET_PC, 32'h0000_0000, PC value fetched first after reset
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) driven on flush/reset

Ports:
clk  in  1  system clock, all flops on posedge
rst  in  1  asynchronous, active-low reset (asserted when 0)
stall  in  1  hold IF/ID register and PC (hazard unit)
redirect  in  1  flush IF/ID and load new PC
redirect_pc  in  32  target PC; bits [1:0] forced to 0 internally
im_req  out  1  fetch request valid
im_addr  out  32  fetch address, word aligned
im_gnt  in  1  memory accepts request this cycle
im_rvalid  in  1  response data valid; earliest one cycle after gnt
im_rdata  in  32  instruction word
IF_pc_out  out  32  PC of instruction in IF/ID
IF_instr_out  out  32  instruction in IF/ID
IF_valid  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (rst=0, async):
  - pc_q=RESET_PC, state=IDLE, kill=0, buffer empty.
  - IF_pc_out=0, IF_instr_out=NOP_INSTR, IF_valid=0, im_req=0.
- States: IDLE, REQ, WAIT, HOLD. im_req=(state==REQ); im_addr=pc_q.
- IDLE: first posedge after reset release -> REQ.
- REQ:
  - im_addr stable until im_gnt.
  - gnt -> WAIT.
  - redirect without gnt: pc_q<=redirect_pc, stay REQ.
  - redirect with gnt: pc_q<=redirect_pc, kill<=1, go WAIT.
- WAIT (one outstanding request max):
  - rvalid, kill=0, stall=0, no redirect: IF_instr_out<=im_rdata, IF_pc_out<=pc_q, IF_valid<=1, pc_q<=pc_q+4 (mod 2^32), go REQ.
  - rvalid, kill=0, stall=1: capture into skid buffer, go HOLD.
  - rvalid with kill=1 or redirect: discard data, kill<=0, go REQ.
  - redirect without rvalid: pc_q<=redirect_pc, kill<=1, stay WAIT.
- HOLD:
  - stall falls: load buffer into IF/ID (valid=1), pc_q+=4, go REQ.
  - redirect: drop buffer, pc_q<=redirect_pc, go REQ.
- stall=1 and no redirect: IF_pc_out, IF_instr_out and IF_valid hold in every state.
- redirect (any state, any stall): next edge IF_instr_out=NOP_INSTR, IF_valid=0, IF_pc_out unchanged.
- Timing:
  - Minimum latency req->IF/ID load is 2 cycles (gnt in request cycle, rvalid next).
  - Best-case throughput is 1 instruction per 2 cycles.
- Reset mid-transaction: state and kill cleared; any late rvalid after reset release is ignored while in IDLE/REQ.
- Spurious rvalid in IDLE, REQ or HOLD is ignored.

Optional Feature:
- Macro IF_PERF_CNT_EN. When defined, two extra outputs:
  - perf_fetch_cnt [31:0]: increments on each IF/ID load with valid=1.
  - perf_stall_cnt [31:0]: increments each cycle stall=1 while IF_valid=1.
  - Both reset to 0 and wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package if_pkg holds:
  - state enum (IDLE, REQ, WAIT, HOLD).
  - NOP_INSTR and default RESET_PC constants.
  - PC width constant (32).
- One sub-module, fetch_skid_buf: 1-entry data/pc buffer with load, drain and clear.

Test Plan:
- Reset release, gnt same cycle, rvalid next: im_addr 0x0,0x4,0x8 -> IF_pc_out 0x0,0x4,0x8 with instr words in order, IF_valid=1.
- stall=1 for 3 cycles while rvalid arrives at 0x8 -> IF/ID holds 0x4, then 0x8 loads 1 cycle after stall falls; no duplicate fetch of 0x8.
- redirect to 0x100 during WAIT for 0xC -> 0xC response discarded, next im_addr=0x100, IF_instr_out=0x00000013 with IF_valid=0 meanwhile.
- redirect and rvalid same cycle, plus redirect and stall together -> data dropped, flush wins, next fetch at redirect_pc.
- redirect_pc=0x103 -> im_addr=0x100. Fetch at 0xFFFFFFFC -> next PC 0x0.
- rst pulsed low while in WAIT -> all outputs at reset values asynchronously, and fetch restarts at RESET_PC.
- With IF_PERF_CNT_EN: 5 fetches and 3 stall cycles -> perf_fetch_cnt=5, perf_stall_cnt=3.
